cla_serial_adder: RTL and testbench

Multi-cycle WIDTH-bit adder that sequences one 4-bit carry-lookahead slice over the operand, one nibble per clock, LSB nibble first. It sits directly upstream of the 4-bit CLA adder. It latches the operands, feeds each nibble pair and the running carry into a single `cla_4bit` instance, and collects that instance's `sum`, `cout`, `Pg` and `Gg` into a full-width result with group flags. The block trades latency for area in the HP-AU datapath and exposes a start/busy/done handshake to the controller.

---
 rtl/cla_serial_adder.sv | 134 +++++++++++++
 tb/tb_cla_serial_adder.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/cla_serial_adder.sv
// Serial WIDTH-bit adder: one 4-bit carry-lookahead slice is reused for one nibble per clock, LSB nibble first.
// Result, carry, overflow and whole-word propagate/generate are registered once the last nibble is done.

module cla_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout,
  output logic       pg,
  output logic       gg
);
  logic [3:0] p, g, c;

  always_comb begin
    p    = a ^ b;
    g    = a & b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    pg   = &p;
    gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    cout = gg | (pg & cin);
    sum  = p ^ c;
  end
endmodule

module cla_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             pg,
  output logic             gg
);
  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

  generate
    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
      $error("cla_serial_adder: WIDTH must be a multiple of 4 and at least 4");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nxt;

  logic [WIDTH-1:0] a_lat, b_lat, sum_int, sum_nxt;
  logic [IW-1:0]    idx;
  logic             carry, pg_acc, gg_acc;
  logic [3:0]       nib_sum;
  logic             nib_cout, nib_pg, nib_gg;
  logic             accept, last;

  cla_4bit u_cla (
    .a    (a_lat[4*idx +: 4]),
    .b    (b_lat[4*idx +: 4]),
    .cin  (carry),
    .sum  (nib_sum),
    .cout (nib_cout),
    .pg   (nib_pg),
    .gg   (nib_gg)
  );

  assign accept = start && (state == IDLE || state == DONE);
  assign last   = (state == BUSY) && (idx == IW'(NIB - 1));
  assign busy   = (state == BUSY);
  assign done   = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    sum_nxt   = sum_int;
    sum_nxt[4*idx +: 4] = nib_sum;
    case (state)
      IDLE:    if (start) state_nxt = BUSY;
      BUSY:    if (last)  state_nxt = DONE;
      DONE:    state_nxt = start ? BUSY : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_lat   <= '0;
      b_lat   <= '0;
      sum_int <= '0;
      idx     <= '0;
      carry   <= 1'b0;
      pg_acc  <= 1'b0;
      gg_acc  <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
      pg      <= 1'b0;
      gg      <= 1'b0;
    end else if (accept) begin
      a_lat  <= a;
      b_lat  <= b;
      carry  <= cin;
      idx    <= '0;
      pg_acc <= 1'b1;
      gg_acc <= 1'b0;
    end else if (state == BUSY) begin
      sum_int <= sum_nxt;
      carry   <= nib_cout;
      pg_acc  <= pg_acc & nib_pg;
      gg_acc  <= nib_gg | (nib_pg & gg_acc);
      // idx stops at the last nibble rather than wrapping
      if (!last) idx <= idx + 1'b1;
      if (last) begin
        sum  <= sum_nxt;
        cout <= nib_cout;
        pg   <= pg_acc & nib_pg;
        gg   <= nib_gg | (nib_pg & gg_acc);
        ovf  <= (a_lat[WIDTH-1] == b_lat[WIDTH-1]) && (nib_sum[3] != a_lat[WIDTH-1]);
      end
    end
  end
endmodule

// File: tb/tb_cla_serial_adder.sv
// Self-checking bench for cla_serial_adder (WIDTH=16): directed cases from the plan plus randomized operands
// compared against a plain-arithmetic reference model.

module tb_cla_serial_adder;
  logic        clk = 1'b0;
  logic        rst, start, cin;
  logic [15:0] a, b;
  logic        busy, done, cout, ovf, pg, gg;
  logic [15:0] sum;

  int n_cmp = 0;
  int n_bad = 0;

  cla_serial_adder #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf), .pg(pg), .gg(gg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [15:0] x, input logic [15:0] y, input logic c,
                       output logic [15:0] s, output logic co, output logic ov,
                       output logic p, output logic g);
    logic [16:0] t, t0;
    t  = {1'b0, x} + {1'b0, y} + {16'd0, c};
    t0 = {1'b0, x} + {1'b0, y};
    s  = t[15:0];
    co = t[16];
    ov = (x[15] == y[15]) && (s[15] != x[15]);
    p  = ((x ^ y) == 16'hFFFF);
    g  = t0[16];
  endtask

  task automatic chk_result(input string tag, input logic [15:0] x, input logic [15:0] y, input logic c);
    logic [15:0] s;
    logic co, ov, p, g;
    model(x, y, c, s, co, ov, p, g);
    chk({tag, ".sum"},  {16'd0, sum}, {16'd0, s});
    chk({tag, ".cout"}, {31'd0, cout}, {31'd0, co});
    chk({tag, ".ovf"},  {31'd0, ovf}, {31'd0, ov});
    chk({tag, ".pg"},   {31'd0, pg}, {31'd0, p});
    chk({tag, ".gg"},   {31'd0, gg}, {31'd0, g});
    chk({tag, ".inv"},  {31'd0, cout}, {31'd0, gg | (pg & c)});
  endtask

  // Called at the negedge after the start edge; returns at the negedge of the done cycle.
  task automatic wait_done(input int pulse_at, output int cnt, output bit seen);
    cnt = 0;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      if (done) begin
        seen = 1;
        break;
      end
      if (busy) cnt++;
      start = (cnt == pulse_at);
      a = 16'($urandom);
      b = 16'($urandom);
      cin = 1'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [15:0] x, input logic [15:0] y, input logic c,
                        input int pulse_at);
    int cnt;
    bit seen;
    @(negedge clk);
    a = x; b = y; cin = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(pulse_at, cnt, seen);
    chk({tag, ".seen"}, {31'd0, seen}, 32'd1);
    chk({tag, ".lat"}, cnt, 32'd4);
    chk({tag, ".busy_at_done"}, {31'd0, busy}, 32'd0);
    chk_result(tag, x, y, c);
  endtask

  initial begin
    int cnt;
    bit seen;
    logic [15:0] rx, ry;
    logic rc;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst.busy", {31'd0, busy}, 32'd0);
    chk("rst.done", {31'd0, done}, 32'd0);
    chk("rst.outs", {11'd0, sum, cout, ovf, pg, gg}, 32'd0);
    rst = 1'b0;

    run_op("t1", 16'h0002, 16'h0003, 1'b0, -1);
    @(negedge clk);
    chk("t1.done_pulse", {31'd0, done}, 32'd0);
    chk_result("t1.hold", 16'h0002, 16'h0003, 1'b0);

    run_op("t2", 16'hFFFF, 16'h0000, 1'b1, -1);
    run_op("t3", 16'h8000, 16'h8000, 1'b0, -1);
    run_op("t4", 16'h7FFF, 16'h0001, 1'b0, 2);

    // back-to-back: restart from the DONE cycle
    run_op("b2b1", 16'h1234, 16'h4321, 1'b0, -1);
    a = 16'hFFFF; b = 16'h0001; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("b2b.no_gap", {31'd0, busy}, 32'd1);
    chk_result("b2b.hold", 16'h1234, 16'h4321, 1'b0);
    wait_done(-1, cnt, seen);
    chk("b2b2.seen", {31'd0, seen}, 32'd1);
    chk("b2b2.lat", cnt, 32'd4);
    chk_result("b2b2", 16'hFFFF, 16'h0001, 1'b0);

    // reset in the middle of an operation
    @(negedge clk);
    a = 16'hAAAA; b = 16'h5555; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort.busy", {31'd0, busy}, 32'd0);
    chk("abort.outs", {11'd0, sum, cout, ovf, pg, gg}, 32'd0);
    seen = 0;
    repeat (6) begin
      if (done) seen = 1;
      @(negedge clk);
    end
    chk("abort.no_done", {31'd0, seen}, 32'd0);
    run_op("after_rst", 16'hAAAA, 16'h5555, 1'b1, -1);

    for (int i = 0; i < 30; i++) begin
      rx = 16'($urandom);
      ry = (i % 5 == 0) ? ~rx : 16'($urandom);
      rc = 1'($urandom);
      run_op("rand", rx, ry, rc, (i % 3 == 0) ? int'($urandom_range(1, 3)) : -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
